ln_range_reduce: RTL

- Front-end stage directly upstream of ln_fast_core.
- Accepts an arbitrary IEEE-754 single y and splits it as y = 2^k * m', with m' in [~0.707, ~1.414). It then issues x = m' - 1 as a float, so |x| < 0.42 and the core's series converges; the core's error output never fires.
- Emits k and an exception class alongside, for the downstream reconstruction stage: ln y = k*ln2 + ln(1+x).
- Throttles acceptance with an in-flight credit counter, because the core has no backpressure.

---
 rtl/ln_pkg.sv | 20 ++
 rtl/ln_range_reduce_lzc25.sv | 14 +
 rtl/ln_range_reduce.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ln_pkg.sv
// Shared constants for the ln front end (ln_range_reduce) and ln_fast_core.
// Float field layout, class codes, sqrt(2) split point and core latency.
package ln_pkg;

  localparam int FLT_EXP_W  = 8;
  localparam int FLT_FRAC_W = 23;
  localparam logic [7:0] FLT_BIAS = 8'd127;

  localparam logic [1:0] CLS_NORMAL = 2'd0;
  localparam logic [1:0] CLS_ZERO   = 2'd1;
  localparam logic [1:0] CLS_NEG    = 2'd2;
  localparam logic [1:0] CLS_INF    = 2'd3;

  // Fraction of ceil(sqrt(2) * 2^23); mantissas at or above fold down by 2.
  localparam logic [22:0] SQRT2_FRAC = 23'h3504F4;

  // The one value shared with ln_fast_core.
  localparam int CORE_LATENCY = 75;

endpackage

// File: rtl/ln_range_reduce_lzc25.sv
// lzc25: combinational leading-zero count of a 25-bit word.
// An all-zero input reports 25.
module lzc25 (
  input  logic [24:0] d_i,
  output logic [4:0]  lz_o
);

  always_comb begin
    lz_o = 5'd25;
    for (int i = 0; i < 25; i++)
      if (d_i[i]) lz_o = 5'(24 - i);
  end

endmodule

// File: rtl/ln_range_reduce.sv
// ln_range_reduce: y = 2^k * m', issue x = m' - 1 to ln_fast_core, 3-cycle pipe.
// Optional LN_REDUCE_STATS_EN adds accept / stall counters.
module ln_range_reduce
  import ln_pkg::*;
#(
  parameter int MAX_INFLIGHT = CORE_LATENCY + 5,
  parameter int CNT_W        = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_y,
  input  logic             retire,
  output logic [31:0]      x,
  output logic             start,
  output logic [8:0]       k_out,
  output logic [1:0]       cls,
  output logic [CNT_W-1:0] inflight,
  output logic             credit_err
`ifdef LN_REDUCE_STATS_EN
  ,
  output logic [31:0]      stat_accepts,
  output logic [31:0]      stat_stalls
`endif
);

  logic             accept;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic             cerr_q, cerr_d;

  logic        s_in;
  logic [7:0]  e_in;
  logic [22:0] f_in;
  logic        hi;
  logic [1:0]  cls1_d;
  logic [8:0]  k1_d;
  logic [24:0] d1_d;

  logic        v1_q, neg1_q, sh1_q;
  logic [1:0]  cls1_q;
  logic [8:0]  k1_q;
  logic [24:0] d1_q;

  logic [4:0]  lz1;
  logic        v2_q, neg2_q, sh2_q;
  logic [1:0]  cls2_q;
  logic [8:0]  k2_q;
  logic [24:0] d2_q;
  logic [4:0]  lz2_q;

  logic [4:0]  p3;
  logic [7:0]  ex3;
  logic [22:0] man3;
  logic [31:0] x_d;

  logic        start_q;
  logic [31:0] x_q;
  logic [8:0]  k_q;
  logic [1:0]  cls_q;

  assign in_ready = (inflight_q < CNT_W'(MAX_INFLIGHT));
  assign accept   = in_valid & in_ready;

  always_comb begin
    inflight_d = inflight_q;
    cerr_d     = cerr_q;
    if (accept && !retire)
      inflight_d = inflight_q + CNT_W'(1);
    else if (!accept && retire) begin
      if (inflight_q == '0) cerr_d = 1'b1;
      else inflight_d = inflight_q - CNT_W'(1);
    end
  end

  assign s_in = in_y[31];
  assign e_in = in_y[30:23];
  assign f_in = in_y[22:0];
  assign hi   = (f_in >= SQRT2_FRAC);

  always_comb begin
    priority case (1'b1)
      e_in == 8'hFF: cls1_d = CLS_INF;
      e_in == 8'h00: cls1_d = CLS_ZERO;
      s_in:          cls1_d = CLS_NEG;
      default:       cls1_d = CLS_NORMAL;
    endcase
  end

  // Non-normal classes carry D = 0 and k = 0 so they pack to x = 0.
  always_comb begin
    k1_d = '0;
    d1_d = '0;
    if (cls1_d == CLS_NORMAL) begin
      if (hi) begin
        k1_d = {1'b0, e_in} - 9'd126;
        d1_d = 25'h0800000 - {2'b00, f_in};
      end else begin
        k1_d = {1'b0, e_in} - 9'd127;
        d1_d = {2'b00, f_in};
      end
    end
  end

  lzc25 u_lzc (
    .d_i  (d1_q),
    .lz_o (lz1)
  );

  assign p3   = 5'd24 - lz2_q;
  assign ex3  = FLT_BIAS + {3'b000, p3} - (sh2_q ? 8'd24 : 8'd23);
  assign man3 = 23'((d2_q << lz2_q) >> 1);
  assign x_d  = (d2_q == '0) ? 32'h0 : {neg2_q, ex3, man3};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q <= '0;
      cerr_q     <= 1'b0;
      v1_q       <= 1'b0;
      neg1_q     <= 1'b0;
      sh1_q      <= 1'b0;
      cls1_q     <= '0;
      k1_q       <= '0;
      d1_q       <= '0;
      v2_q       <= 1'b0;
      neg2_q     <= 1'b0;
      sh2_q      <= 1'b0;
      cls2_q     <= '0;
      k2_q       <= '0;
      d2_q       <= '0;
      lz2_q      <= '0;
      start_q    <= 1'b0;
      x_q        <= '0;
      k_q        <= '0;
      cls_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      cerr_q     <= cerr_d;
      v1_q       <= accept;
      neg1_q     <= hi;
      sh1_q      <= hi;
      cls1_q     <= cls1_d;
      k1_q       <= k1_d;
      d1_q       <= d1_d;
      v2_q       <= v1_q;
      neg2_q     <= neg1_q;
      sh2_q      <= sh1_q;
      cls2_q     <= cls1_q;
      k2_q       <= k1_q;
      d2_q       <= d1_q;
      lz2_q      <= lz1;
      start_q    <= v2_q;
      if (v2_q) begin
        x_q   <= x_d;
        k_q   <= k2_q;
        cls_q <= cls2_q;
      end
    end
  end

  assign x          = x_q;
  assign start      = start_q;
  assign k_out      = k_q;
  assign cls        = cls_q;
  assign inflight   = inflight_q;
  assign credit_err = cerr_q;

`ifdef LN_REDUCE_STATS_EN
  logic [31:0] acc_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (accept) acc_cnt_q <= acc_cnt_q + 32'd1;
      if (in_valid && !in_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stat_accepts = acc_cnt_q;
  assign stat_stalls  = stall_cnt_q;
`endif

endmodule
